pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 66 ++++++
 tb/tb_pipe_stage_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Cascaded pipeline register: DEPTH stages of {valid, payload}. Optional event counters with PIPE_STAGE_REG_STATS_EN.
// Latency: exactly DEPTH advancing edges from in_* to out_*; outputs come straight from the last stage's flops.
// Backpressure: stall freezes every stage and drops in_*; flush zeroes every stage and wins over stall.
module pipe_stage_reg #(
    parameter int DATA_W = 108,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
`ifdef PIPE_STAGE_REG_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must lie in 1..8");
    end

    logic [DEPTH-1:0]  stg_vld;
    logic [DATA_W-1:0] stg_dat [DEPTH];

    // Bubbles carry an all-zero payload so downstream enables decode as inactive.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stg_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_dat[k] <= '0;
            end
        end else if (!stall) begin
            stg_vld[0] <= in_valid;
            stg_dat[0] <= in_valid ? in_data : '0;
            for (int k = 1; k < DEPTH; k++) begin
                stg_vld[k] <= stg_vld[k-1];
                stg_dat[k] <= stg_dat[k-1];
            end
        end
    end

    assign out_valid = stg_vld[DEPTH-1];
    assign out_data  = stg_dat[DEPTH-1];

`ifdef PIPE_STAGE_REG_STATS_EN
    // Saturating counters; a stall hidden under a flush is not counted as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
            if (stall && !flush && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives four pipe_stage_reg instances (varied DEPTH/DATA_W) with shared controls, checked against a queue model.
module tb_pipe_stage_reg;

    localparam int N = 4;
    localparam int DEP [N] = '{1, 2, 3, 8};
    localparam int WID [N] = '{8, 16, 108, 1};

    logic         clk = 1'b0;
    logic         rst, in_valid, stall, flush;
    logic [107:0] in_data;

    logic         ov_a, ov_b, ov_c, ov_d;
    logic [7:0]   od_a;
    logic [15:0]  od_b;
    logic [107:0] od_c;
    logic [0:0]   od_d;
`ifdef PIPE_STAGE_REG_STATS_EN
    logic [15:0]  sc_a, fc_a, sc_b, fc_b, sc_c, fc_c, sc_d, fc_d;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .DEPTH(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[7:0]),
        .stall(stall), .flush(flush),
`ifdef PIPE_STAGE_REG_STATS_EN
        .stall_cnt(sc_a), .flush_cnt(fc_a),
`endif
        .out_valid(ov_a), .out_data(od_a));

    pipe_stage_reg #(.DATA_W(16), .DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[15:0]),
        .stall(stall), .flush(flush),
`ifdef PIPE_STAGE_REG_STATS_EN
        .stall_cnt(sc_b), .flush_cnt(fc_b),
`endif
        .out_valid(ov_b), .out_data(od_b));

    pipe_stage_reg #(.DATA_W(108), .DEPTH(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .stall(stall), .flush(flush),
`ifdef PIPE_STAGE_REG_STATS_EN
        .stall_cnt(sc_c), .flush_cnt(fc_c),
`endif
        .out_valid(ov_c), .out_data(od_c));

    pipe_stage_reg #(.DATA_W(1), .DEPTH(8)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[0:0]),
        .stall(stall), .flush(flush),
`ifdef PIPE_STAGE_REG_STATS_EN
        .stall_cnt(sc_d), .flush_cnt(fc_d),
`endif
        .out_valid(ov_d), .out_data(od_d));

    typedef struct {
        logic         v;
        logic [107:0] d;
    } slot_t;

    // Each model pipe is a queue of exactly DEPTH slots: newest at front, output at back.
    slot_t mq [N][$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [107:0] wmask(input int w);
        logic [107:0] one = 108'd1;
        return (w >= 108) ? {108{1'b1}} : (one << w) - one;
    endfunction

    function automatic void model_edge(input logic r, v, input logic [107:0] d, input logic s, f);
        slot_t z, n;
        z.v = 1'b0;
        z.d = '0;
        for (int i = 0; i < N; i++) begin
            if (r || f) begin
                mq[i].delete();
                for (int k = 0; k < DEP[i]; k++) mq[i].push_back(z);
            end else if (!s) begin
                n.v = v;
                n.d = v ? (d & wmask(WID[i])) : '0;
                mq[i].push_front(n);
                void'(mq[i].pop_back());
            end
        end
    endfunction

    task automatic compare_all();
        logic         gv [N];
        logic [107:0] gd [N];
        slot_t        e;
        gv = '{ov_a, ov_b, ov_c, ov_d};
        gd = '{108'(od_a), 108'(od_b), od_c, 108'(od_d)};
        for (int i = 0; i < N; i++) begin
            e = mq[i][mq[i].size()-1];
            check($sformatf("out_valid[D%0d]", DEP[i]), 128'(gv[i]), 128'(e.v));
            check($sformatf("out_data[D%0d]", DEP[i]), 128'(gd[i]), 128'(e.d));
        end
    endtask

    task automatic drive(input logic r, v, input logic [107:0] d, input logic s, f);
        rst = r; in_valid = v; in_data = d; stall = s; flush = f;
        @(posedge clk);
        model_edge(r, v, d, s, f);
        #1;
        compare_all();
    endtask

    initial begin
        logic [107:0] ones = {108{1'b1}};
        rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < N; i++) mq[i].delete();

        drive(1, 1, ones, 1, 1);
        drive(1, 0, '0, 0, 0);
        check("reset_out_c", 128'({ov_c, od_c}), 128'd0);

        // Depth-1 streaming: 1, 2, 3 appear on consecutive edges.
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 108'(k), 0, 0);
            check($sformatf("stream_a_%0d", k), 128'({ov_a, od_a}), 128'({1'b1, 8'(k)}));
        end
        drive(0, 0, '0, 0, 1);

        // Depth-3 with a two-edge stall: 0xA surfaces on the fifth edge; stalled input is lost.
        drive(0, 1, 108'hA, 0, 0);
        drive(0, 1, 108'h55, 1, 0);
        drive(0, 1, 108'h66, 1, 0);
        drive(0, 0, '0, 0, 0);
        check("stall_c_early", 128'(ov_c), 128'd0);
        drive(0, 0, '0, 0, 0);
        check("stall_c_out", 128'({ov_c, od_c}), {19'd0, 1'b1, 108'hA});
        drive(0, 0, '0, 0, 0);
        check("stall_c_lost", 128'({ov_c, od_c}), 128'd0);

        // Flush with stall while two entries sit in the depth-2 pipe.
        drive(0, 1, 108'hBEEF, 0, 0);
        drive(0, 1, 108'hCAFE, 0, 0);
        drive(0, 1, 108'h1234, 1, 1);
        check("flush_b", 128'({ov_b, od_b}), 128'd0);
        drive(0, 0, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        check("flush_b_stays", 128'({ov_b, od_b}), 128'd0);

        // Invalid input with all-ones payload becomes a zero bubble.
        drive(0, 0, ones, 0, 0);
        check("bubble_a", 128'({ov_a, od_a}), 128'd0);

        // Reset during stall, then 0x5 emerges after DEPTH edges.
        drive(0, 1, 108'h77, 0, 0);
        drive(0, 1, 108'h88, 1, 0);
        drive(1, 1, 108'h99, 1, 0);
        check("rst_mid_stall_c", 128'({ov_c, od_c}), 128'd0);
        drive(0, 1, 108'h5, 0, 0);
        check("post_rst_a", 128'({ov_a, od_a}), 128'({1'b1, 8'h5}));
        drive(0, 0, '0, 0, 0);
        drive(0, 0, '0, 0, 0);
        check("post_rst_c", 128'({ov_c, od_c}), {19'd0, 1'b1, 108'h5});

        for (int t = 0; t < 600; t++) begin
            drive(($urandom_range(63) == 0), $urandom_range(1),
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(3) == 0), ($urandom_range(9) == 0));
        end

`ifdef PIPE_STAGE_REG_STATS_EN
        drive(1, 0, '0, 0, 0);
        check("cnt_reset", 128'({sc_a, fc_a}), 128'd0);
        for (int t = 0; t < 70000; t++) begin
            rst = 0; in_valid = 1; in_data = 108'(t); stall = 1; flush = 0;
            @(posedge clk);
        end
        #1;
        check("stall_cnt_sat", 128'(sc_a), 128'hFFFF);
        check("stall_cnt_sat_d", 128'(sc_d), 128'hFFFF);
        for (int t = 0; t < 3; t++) drive(0, 1, '0, 1, 1);
        check("flush_cnt", 128'(fc_a), 128'd3);
        check("stall_cnt_hold", 128'(sc_a), 128'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
